// File: rtl/bev_bridge_arb.sv
// Round-robin arbiter sharing one bridge between two requesters, one transaction in flight.
// Optional WAIT timeout is compiled in with `define BEV_BRIDGE_ARB_TIMEOUT_EN.
module bev_bridge_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_r_wb,
  input  logic [7:0]  req_addr0,
  input  logic [7:0]  req_addr1,
  input  logic [63:0] req_data_w0,
  input  logic [63:0] req_data_w1,
  output logic [1:0]  req_ack,
  output logic [1:0]  resp_valid,
  output logic [63:0] resp_data,
  output logic        resp_err,
  output logic        busy,
  output logic        C_in_valid,
  output logic        C_r_wb,
  output logic [7:0]  C_addr,
  output logic [63:0] C_data_w,
  input  logic        C_out_valid,
  input  logic [63:0] C_data_r
);

  // Handshake: req_valid is a level held until req_ack; req_ack and C_in_valid pulse
  // together once per grant; resp_valid pulses once per grant on completion or timeout.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        last_grant;
  logic        last_grant_d;
  logic        grant_q;
  logic        grant_q_d;
  logic        gnt_sel;
  logic        timeout_hit;

  logic [1:0]  req_ack_d;
  logic [1:0]  resp_valid_d;
  logic [63:0] resp_data_d;
  logic        resp_err_d;
  logic        busy_d;
  logic        c_in_valid_d;
  logic        c_r_wb_d;
  logic [7:0]  c_addr_d;
  logic [63:0] c_data_w_d;

  // With both requesters pending, the one not served last wins.
  always_comb begin
    if (req_valid == 2'b11) begin
      gnt_sel = ~last_grant;
    end else begin
      gnt_sel = req_valid[1];
    end
  end

`ifdef BEV_BRIDGE_ARB_TIMEOUT_EN
  logic [9:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= 10'd0;
    end else if (state == S_ISSUE) begin
      wait_cnt <= 10'd0;
    end else if (state == S_WAIT && !timeout_hit) begin
      wait_cnt <= wait_cnt + 10'd1;
    end
  end

  // A completion in the same cycle as the last count takes priority.
  always_comb begin
    timeout_hit = (state == S_WAIT) && !C_out_valid && (wait_cnt == 10'd1023);
  end
`else
  always_comb begin
    timeout_hit = 1'b0;
  end
`endif

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      grant_q    <= 1'b0;
      req_ack    <= 2'b00;
      resp_valid <= 2'b00;
      resp_data  <= 64'd0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
      C_in_valid <= 1'b0;
      C_r_wb     <= 1'b1;
      C_addr     <= 8'd0;
      C_data_w   <= 64'd0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_d;
      grant_q    <= grant_q_d;
      req_ack    <= req_ack_d;
      resp_valid <= resp_valid_d;
      resp_data  <= resp_data_d;
      resp_err   <= resp_err_d;
      busy       <= busy_d;
      C_in_valid <= c_in_valid_d;
      C_r_wb     <= c_r_wb_d;
      C_addr     <= c_addr_d;
      C_data_w   <= c_data_w_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (|req_valid) begin
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (C_out_valid || timeout_hit) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs; bridge fields hold while idle.
  always_comb begin
    last_grant_d = last_grant;
    grant_q_d    = grant_q;
    req_ack_d    = 2'b00;
    resp_valid_d = 2'b00;
    resp_data_d  = resp_data;
    resp_err_d   = 1'b0;
    busy_d       = (state_nxt != S_IDLE);
    c_in_valid_d = 1'b0;
    c_r_wb_d     = C_r_wb;
    c_addr_d     = C_addr;
    c_data_w_d   = C_data_w;
    case (state)
      S_IDLE: begin
        if (|req_valid) begin
          last_grant_d = gnt_sel;
          grant_q_d    = gnt_sel;
          req_ack_d    = gnt_sel ? 2'b10 : 2'b01;
          c_in_valid_d = 1'b1;
          c_r_wb_d     = gnt_sel ? req_r_wb[1] : req_r_wb[0];
          c_addr_d     = gnt_sel ? req_addr1 : req_addr0;
          c_data_w_d   = gnt_sel ? req_data_w1 : req_data_w0;
        end
      end
      S_WAIT: begin
        if (C_out_valid) begin
          resp_valid_d = grant_q ? 2'b10 : 2'b01;
          resp_data_d  = C_data_r;
        end else if (timeout_hit) begin
          resp_valid_d = grant_q ? 2'b10 : 2'b01;
          resp_data_d  = 64'd0;
          resp_err_d   = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_bev_bridge_arb.sv
// Directed bench for bev_bridge_arb: per-cycle vector table plus contention, reset and timeout sequences.
module tb_bev_bridge_arb;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_r_wb;
  logic [7:0]  req_addr0;
  logic [7:0]  req_addr1;
  logic [63:0] req_data_w0;
  logic [63:0] req_data_w1;
  logic [1:0]  req_ack;
  logic [1:0]  resp_valid;
  logic [63:0] resp_data;
  logic        resp_err;
  logic        busy;
  logic        C_in_valid;
  logic        C_r_wb;
  logic [7:0]  C_addr;
  logic [63:0] C_data_w;
  logic        C_out_valid;
  logic [63:0] C_data_r;

  bev_bridge_arb dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_r_wb    (req_r_wb),
    .req_addr0   (req_addr0),
    .req_addr1   (req_addr1),
    .req_data_w0 (req_data_w0),
    .req_data_w1 (req_data_w1),
    .req_ack     (req_ack),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .resp_err    (resp_err),
    .busy        (busy),
    .C_in_valid  (C_in_valid),
    .C_r_wb      (C_r_wb),
    .C_addr      (C_addr),
    .C_data_w    (C_data_w),
    .C_out_valid (C_out_valid),
    .C_data_r    (C_data_r)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  rv;
    logic [1:0]  rwb;
    logic [7:0]  a0;
    logic [7:0]  a1;
    logic [63:0] d0;
    logic [63:0] d1;
    logic        cov;
    logic [63:0] cdr;
    logic [1:0]  e_ack;
    logic        e_cin;
    logic        e_busy;
    logic        e_rwb;
    logic [7:0]  e_addr;
    logic [63:0] e_dw;
    logic [1:0]  e_resp;
    logic        e_err;
    logic [63:0] e_rdata;
  } vec_t;

  vec_t        vecs[$];
  logic [1:0]  exp_q[$];
  int          n_cmp;
  int          n_err;

  localparam logic [63:0] D_RD  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D_WR  = 64'hFFF0_0000_0000_001F;
  localparam logic [63:0] D_R2  = 64'hDEAD_BEEF_0000_5555;
  localparam logic [63:0] D_X   = 64'h5A5A_A5A5_3C3C_C3C3;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    req_valid   = 2'b00;
    req_r_wb    = 2'b00;
    req_addr0   = 8'h00;
    req_addr1   = 8'h00;
    req_data_w0 = 64'd0;
    req_data_w1 = 64'd0;
    C_out_valid = 1'b0;
    C_data_r    = 64'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic [1:0] rv, input logic [1:0] rwb, input logic [7:0] a0,
                         input logic [7:0] a1, input logic [63:0] d0, input logic [63:0] d1,
                         input logic cov, input logic [63:0] cdr, input logic [1:0] e_ack,
                         input logic e_cin, input logic e_busy, input logic e_rwb,
                         input logic [7:0] e_addr, input logic [63:0] e_dw,
                         input logic [1:0] e_resp, input logic e_err, input logic [63:0] e_rdata);
    vec_t v;
    v.rv = rv; v.rwb = rwb; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.cov = cov; v.cdr = cdr; v.e_ack = e_ack; v.e_cin = e_cin; v.e_busy = e_busy;
    v.e_rwb = e_rwb; v.e_addr = e_addr; v.e_dw = e_dw; v.e_resp = e_resp;
    v.e_err = e_err; v.e_rdata = e_rdata;
    vecs.push_back(v);
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    check({tag, " req_ack"},    req_ack,    v.e_ack);
    check({tag, " C_in_valid"}, C_in_valid, v.e_cin);
    check({tag, " busy"},       busy,       v.e_busy);
    check({tag, " C_r_wb"},     C_r_wb,     v.e_rwb);
    check({tag, " C_addr"},     C_addr,     v.e_addr);
    check({tag, " C_data_w"},   C_data_w,   v.e_dw);
    check({tag, " resp_valid"}, resp_valid, v.e_resp);
    check({tag, " resp_err"},   resp_err,   v.e_err);
    check({tag, " resp_data"},  resp_data,  v.e_rdata);
  endtask

  initial begin
    vec_t rst_v;
    int   cin_cnt;
    int   n_resp;
    int   delay;
    int   n_cyc;
    int   idle_cnt;
    logic [1:0] pend;

    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    clear_inputs();

    // Read by requester 0: bridge answers 3 cycles after C_in_valid.
    add_vec(2'b01, 2'b01, 8'h2A, 8'h00, 64'd0, 64'd0, 1'b0, 64'd0, 2'b01, 1, 1, 1, 8'h2A, 64'd0, 2'b00, 0, 64'd0);
    add_vec(2'b01, 2'b01, 8'h2A, 8'h00, 64'd0, 64'd0, 1'b0, 64'd0, 2'b00, 0, 1, 1, 8'h2A, 64'd0, 2'b00, 0, 64'd0);
    add_vec(2'b00, 2'b00, 8'h00, 8'h00, 64'd0, 64'd0, 1'b0, 64'd0, 2'b00, 0, 1, 1, 8'h2A, 64'd0, 2'b00, 0, 64'd0);
    add_vec(2'b00, 2'b00, 8'h00, 8'h00, 64'd0, 64'd0, 1'b0, 64'd0, 2'b00, 0, 1, 1, 8'h2A, 64'd0, 2'b00, 0, 64'd0);
    add_vec(2'b00, 2'b00, 8'h00, 8'h00, 64'd0, 64'd0, 1'b1, D_RD,  2'b00, 0, 0, 1, 8'h2A, 64'd0, 2'b01, 0, D_RD);
    add_vec(2'b00, 2'b00, 8'h00, 8'h00, 64'd0, 64'd0, 1'b0, 64'd0, 2'b00, 0, 0, 1, 8'h2A, 64'd0, 2'b00, 0, D_RD);
    // Write by requester 1; completion in ISSUE ignored; req 0 dropped while busy.
    add_vec(2'b10, 2'b00, 8'h11, 8'hFF, D_X,   D_WR,  1'b0, 64'd0, 2'b10, 1, 1, 0, 8'hFF, D_WR,  2'b00, 0, D_RD);
    add_vec(2'b10, 2'b00, 8'h11, 8'hFF, D_X,   D_WR,  1'b1, D_X,   2'b00, 0, 1, 0, 8'hFF, D_WR,  2'b00, 0, D_RD);
    add_vec(2'b01, 2'b01, 8'h11, 8'h00, D_X,   64'd0, 1'b0, 64'd0, 2'b00, 0, 1, 0, 8'hFF, D_WR,  2'b00, 0, D_RD);
    add_vec(2'b00, 2'b00, 8'h00, 8'h00, 64'd0, 64'd0, 1'b1, D_R2,  2'b00, 0, 0, 0, 8'hFF, D_WR,  2'b10, 0, D_R2);
    add_vec(2'b00, 2'b00, 8'h00, 8'h00, 64'd0, 64'd0, 1'b1, D_X,   2'b00, 0, 0, 0, 8'hFF, D_WR,  2'b00, 0, D_R2);
    add_vec(2'b00, 2'b00, 8'h00, 8'h00, 64'd0, 64'd0, 1'b0, 64'd0, 2'b00, 0, 0, 0, 8'hFF, D_WR,  2'b00, 0, D_R2);
    // Tie: requester 1 served last, so 0 wins; 1 is served after 0 completes.
    add_vec(2'b11, 2'b10, 8'h3C, 8'hC3, 64'h1111, 64'h2222, 1'b0, 64'd0, 2'b01, 1, 1, 0, 8'h3C, 64'h1111, 2'b00, 0, D_R2);
    add_vec(2'b11, 2'b10, 8'h3C, 8'hC3, 64'h1111, 64'h2222, 1'b0, 64'd0, 2'b00, 0, 1, 0, 8'h3C, 64'h1111, 2'b00, 0, D_R2);
    add_vec(2'b10, 2'b10, 8'h3C, 8'hC3, 64'h1111, 64'h2222, 1'b1, 64'h77, 2'b00, 0, 0, 0, 8'h3C, 64'h1111, 2'b01, 0, 64'h77);
    add_vec(2'b10, 2'b10, 8'h3C, 8'hC3, 64'h1111, 64'h2222, 1'b0, 64'd0, 2'b10, 1, 1, 1, 8'hC3, 64'h2222, 2'b00, 0, 64'h77);
    add_vec(2'b00, 2'b00, 8'h00, 8'h00, 64'd0, 64'd0, 1'b0, 64'd0, 2'b00, 0, 1, 1, 8'hC3, 64'h2222, 2'b00, 0, 64'h77);
    add_vec(2'b00, 2'b00, 8'h00, 8'h00, 64'd0, 64'd0, 1'b1, 64'h99, 2'b00, 0, 0, 1, 8'hC3, 64'h2222, 2'b10, 0, 64'h99);

    // Reset state
    do_reset();
    rst_v = '{2'b00, 2'b00, 8'h00, 8'h00, 64'd0, 64'd0, 1'b0, 64'd0,
              2'b00, 1'b0, 1'b0, 1'b1, 8'h00, 64'd0, 2'b00, 1'b0, 64'd0};
    check_outputs("reset", rst_v);

    // Table vectors
    for (int i = 0; i < vecs.size(); i++) begin
      req_valid   = vecs[i].rv;
      req_r_wb    = vecs[i].rwb;
      req_addr0   = vecs[i].a0;
      req_addr1   = vecs[i].a1;
      req_data_w0 = vecs[i].d0;
      req_data_w1 = vecs[i].d1;
      C_out_valid = vecs[i].cov;
      C_data_r    = vecs[i].cdr;
      step();
      check_outputs($sformatf("vec%0d", i), vecs[i]);
    end

    // Contention: both requesters valid throughout, bridge answers one cycle into WAIT.
    do_reset();
    exp_q = '{2'b01, 2'b10, 2'b01, 2'b10};
    req_valid = 2'b11;
    req_r_wb  = 2'b11;
    cin_cnt = 0;
    n_resp  = 0;
    delay   = 0;
    pend    = 2'b00;
    for (int cyc = 0; cyc < 60 && n_resp < 4; cyc++) begin
      step();
      if (req_ack != 2'b00) begin
        check("rr grant", req_ack, (exp_q.size() > 0) ? exp_q.pop_front() : 2'b00);
        pend = req_ack;
      end
      if (resp_valid != 2'b00) begin
        check("rr cin per resp", cin_cnt, 1);
        check("rr resp owner", resp_valid, pend);
        cin_cnt = 0;
        n_resp++;
      end
      if (C_in_valid) begin
        cin_cnt++;
        delay = 2;
      end
      C_out_valid = (delay == 1);
      C_data_r    = 64'(n_resp + 1);
      if (delay > 0) delay--;
    end
    check("rr responses", n_resp, 4);
    clear_inputs();

    // Reset while in WAIT abandons the transaction.
    do_reset();
    req_valid = 2'b01;
    req_r_wb  = 2'b01;
    req_addr0 = 8'h42;
    step();
    check("rstwait cin", C_in_valid, 1'b1);
    req_valid = 2'b00;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstwait busy", busy, 1'b0);
    check("rstwait resp", resp_valid, 2'b00);
    C_out_valid = 1'b1;
    C_data_r    = D_X;
    step();
    C_out_valid = 1'b0;
    check("rstwait late resp", resp_valid, 2'b00);
    check("rstwait late data", resp_data, 64'd0);
    check("rstwait late busy", busy, 1'b0);
    req_valid = 2'b10;
    req_r_wb  = 2'b10;
    req_addr1 = 8'h55;
    step();
    check("rstwait next ack", req_ack, 2'b10);
    check("rstwait next addr", C_addr, 8'h55);
    req_valid = 2'b00;
    step();
    C_out_valid = 1'b1;
    C_data_r    = D_R2;
    step();
    C_out_valid = 1'b0;
    check("rstwait next resp", resp_valid, 2'b10);
    check("rstwait next data", resp_data, D_R2);

    // Bridge never answers.
    do_reset();
    req_valid = 2'b01;
    req_r_wb  = 2'b01;
    step();
    check("silent cin", C_in_valid, 1'b1);
    req_valid = 2'b00;
`ifdef BEV_BRIDGE_ARB_TIMEOUT_EN
    n_cyc = 0;
    for (int i = 0; i < 1100 && resp_valid == 2'b00; i++) begin
      step();
      n_cyc++;
    end
    check("timeout latency", n_cyc, 1025);
    check("timeout resp", resp_valid, 2'b01);
    check("timeout err", resp_err, 1'b1);
    check("timeout data", resp_data, 64'd0);
    step();
    check("timeout busy after", busy, 1'b0);
`else
    idle_cnt = 0;
    n_cyc    = 0;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (!busy) idle_cnt++;
      if (resp_valid != 2'b00) n_cyc++;
    end
    check("no timeout busy", idle_cnt, 0);
    check("no timeout resp", n_cyc, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bev_bridge_arb.md
BEV_BRIDGE_ARB -- requirements
Module: bev_bridge_arb

Interface
REQ-001 SHALL have one clock and one reset: the clock is `clk`, and the reset `rst` is synchronous and active-high.
REQ-002 SHALL have these ports (direction, width, meaning):
- `clk`, in, 1: rising-edge clock.
- `rst`, in, 1: synchronous active-high reset.
- `req_valid[1:0]`, in, 2: per-requester transaction request, held high until acked.
- `req_r_wb[1:0]`, in, 2: per requester, 1 = read, 0 = write.
- `req_addr0` / `req_addr1`, in, 8 each: box number.
- `req_data_w0` / `req_data_w1`, in, 64 each: write data.
- `req_ack[1:0]`, out, 2: one-cycle pulse meaning the request was accepted.
- `resp_valid[1:0]`, out, 2: one-cycle pulse meaning the transaction completed.
- `resp_data`, out, 64: read data, valid with `resp_valid`.
- `resp_err`, out, 1: timeout flag, valid with `resp_valid`.
- `busy`, out, 1: high whenever state is not IDLE.
- `C_in_valid`, out, 1: bridge request strobe.
- `C_r_wb`, out, 1: bridge read/write select.
- `C_addr`, out, 8: bridge address.
- `C_data_w`, out, 64: bridge write data.
- `C_out_valid`, in, 1: bridge completion strobe.
- `C_data_r`, in, 64: bridge read data.
REQ-003 SHALL drive all outputs from registers.

Function
REQ-004 SHALL share one bridge between two requesters with at most one transaction outstanding.
REQ-005 SHALL implement the states IDLE, ISSUE and WAIT.
REQ-006 In IDLE with any `req_valid` high, SHALL grant one requester, latch its `r_wb`, address and data, and go to ISSUE.
REQ-007 SHALL arbitrate round-robin: with both requesters valid, grant the one not granted last; with one valid, grant it.
REQ-008 In ISSUE, SHALL drive `C_in_valid`=1 for exactly one cycle with the latched fields, pulse `req_ack[g]` in the same cycle, then go to WAIT.
REQ-009 Reads and writes alike SHALL wait in WAIT for `C_out_valid`.
REQ-010 On `C_out_valid` in WAIT, SHALL register `C_data_r` into `resp_data`, pulse `resp_valid[g]` the next cycle with `resp_err`=0, and return to IDLE.
REQ-011 SHALL meet this cycle timing:
- `req_valid` sampled at cycle 0 gives `C_in_valid` at cycle 1.
- `C_out_valid` at cycle k gives `resp_valid` at cycle k+1.
- The next `C_in_valid` occurs no earlier than cycle k+2.
REQ-012 SHALL ignore `C_out_valid` in IDLE or ISSUE, and SHALL NOT disturb `resp_*` when it does.
REQ-013 A requester SHALL NOT be re-granted before its `resp_valid`. A `req_valid` that stays high after `resp_valid` is a new request.
REQ-014 For a write grant, `resp_data` SHALL be the value returned on `C_data_r`; no masking.
REQ-015 When IDLE, `C_addr`, `C_r_wb` and `C_data_w` SHALL hold their last issued values. `C_r_wb` SHALL be 1 after reset.
REQ-016 A `req_valid` deasserted before ack SHALL be dropped without error; arbitration re-evaluates each IDLE cycle.

Reset
REQ-017 While `rst`=1 at a clock edge, SHALL set:
- state = IDLE;
- `req_ack`, `resp_valid`, `resp_err`, `busy` and `C_in_valid` = 0;
- `resp_data`, `C_addr` and `C_data_w` = 0;
- `C_r_wb` = 1;
- last-grant = requester 1, so requester 0 wins the first tie.
REQ-018 A reset asserted in ISSUE or WAIT SHALL abandon the transaction with no `resp_valid`. A `C_out_valid` arriving after reset release SHALL be ignored per REQ-012.

Configuration
REQ-019 With `BEV_BRIDGE_ARB_TIMEOUT_EN` defined:
- a 10-bit counter SHALL clear on entry to WAIT and increment each WAIT cycle;
- if it reaches 1023 without `C_out_valid`, SHALL pulse `resp_valid[g]` next cycle with `resp_err`=1 and `resp_data`=0, and return to IDLE;
- `C_out_valid` in the same cycle as count 1023 SHALL win, with `resp_err`=0.
REQ-020 Without the macro: no counter; WAIT lasts until `C_out_valid`; `resp_err` is constant 0.

Verification
REQ-021 Single read: `req_valid[0]`=1, `req_addr0`=8'h2A, `r_wb`=1, bridge returns `C_data_r`=64'h0123_4567_89AB_CDEF 3 cycles after `C_in_valid`. Required: `C_addr`=2A at cycle 1, `req_ack[0]` at cycle 1, `resp_valid[0]` at cycle 5 with that data.
REQ-022 Contention: both requesters valid continuously after reset. Required: grant order 0,1,0,1, and exactly one `C_in_valid` between successive `C_out_valid`.
REQ-023 Write: requester 1 writes addr 8'hFF, data 64'hFFF0_0000_0000_001F. Required: `C_r_wb`=0, `C_data_w` matches exactly, and `resp_valid[1]` follows `C_out_valid` by 1 cycle.
REQ-024 Reset in WAIT: reset asserted 2 cycles after `C_in_valid`, then `C_out_valid` pulsed. Required: no `resp_valid`, `busy`=0, and the next request is served normally.
REQ-025 Timeout (macro defined): bridge never responds. Required: `resp_valid[0]`=1, `resp_err`=1, `resp_data`=0 after 1023 WAIT cycles. Without the macro, `busy` stays 1 for 2000 cycles.
